// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width functions and
// a packed status bundle that wrappers can pass around as one signal.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage with one synchronous write port and a registered,
// read-enabled output port that resets to zero.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array gets no reset branch; that keeps it a plain RAM, and the
  // pointers guarantee no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, threshold flags and sticky error
// flags around a fifo_ram. Synchronous active-low reset.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          Data_In,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          Data_Out,
  output logic                      Full,
  output logic                      Empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;
  fifo_status_t  status;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every field is assigned on every pass, so no latch can be inferred.
  always_comb begin
    status.full         = (count == CW'(DEPTH));
    status.empty        = (count == '0);
    status.almost_full  = (count >= CW'(AF_LEVEL));
    status.almost_empty = (count <= CW'(AE_LEVEL));
    status.overflow     = overflow;
    status.underflow    = underflow;
  end

  assign Full         = status.full;
  assign Empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  assign push_ok = wr_en & ~Full;
  assign pop_ok  = rd_en & ~Empty;

  // NOTE: non-blocking updates, so every term here reads the pre-edge state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Set has priority over a coincident clear.
      if (wr_en && Full)   overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd_en && Empty)  underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (Data_In),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (Data_Out)
  );

  a_not_full_and_empty: assert property (@(posedge clk) !(Full && Empty));
  a_full_holds:         assert property (@(posedge clk) Full && !rd_en && reset |=> Full);
  a_empty_holds:        assert property (@(posedge clk) Empty && !wr_en && reset |=> Empty);
  a_count_bound:        assert property (@(posedge clk) count <= CW'(DEPTH));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a default instance and a 32x7 instance, checked
// against a queue-based reference model, a vector table and corner sequences.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, clr_err;
  logic [31:0] din;

  logic [7:0]  dout0;
  logic [3:0]  count0;
  logic        full0, empty0, af0, ae0, ovf0, udf0;
  logic [31:0] dout1;
  logic [2:0]  count1;
  logic        full1, empty1, af1, ae1, ovf1, udf1;

  param_sync_fifo u_dut0 (
    .clk (clk), .reset (reset), .Data_In (din[7:0]), .wr_en (wr_en), .rd_en (rd_en),
    .Data_Out (dout0), .Full (full0), .Empty (empty0), .almost_full (af0),
    .almost_empty (ae0), .count (count0), .overflow (ovf0), .underflow (udf0),
    .clr_err (clr_err)
  );

  param_sync_fifo #(.WIDTH(32), .DEPTH(7), .AF_LEVEL(5), .AE_LEVEL(1)) u_dut1 (
    .clk (clk), .reset (reset), .Data_In (din), .wr_en (wr_en), .rd_en (rd_en),
    .Data_Out (dout1), .Full (full1), .Empty (empty1), .almost_full (af1),
    .almost_empty (ae1), .count (count1), .overflow (ovf1), .underflow (udf1),
    .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  // Which instance is being observed, and its configuration for the model.
  bit          sel = 1'b0;
  int          depth_c = 10, af_c = 8, ae_c = 2;
  logic [31:0] mask_c = 32'hFF;

  logic [31:0] o_dout, o_count;
  logic        o_full, o_empty, o_af, o_ae, o_ovf, o_udf;
  always_comb begin
    o_dout  = sel ? dout1 : 32'(dout0);
    o_count = sel ? 32'(count1) : 32'(count0);
    o_full  = sel ? full1  : full0;
    o_empty = sel ? empty1 : empty0;
    o_af    = sel ? af1    : af0;
    o_ae    = sel ? ae1    : ae0;
    o_ovf   = sel ? ovf1   : ovf0;
    o_udf   = sel ? udf1   : udf0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus the last popped word and error bits.
  logic [31:0] mq[$];
  logic [31:0] m_dout = '0;
  bit          m_ovf = 1'b0, m_udf = 1'b0;

  task automatic compare_model();
    int n;
    n = mq.size();
    check("dout",         o_dout,         m_dout);
    check("count",        o_count,        32'(n));
    check("full",         32'(o_full),    32'(n == depth_c));
    check("empty",        32'(o_empty),   32'(n == 0));
    check("almost_full",  32'(o_af),      32'(n >= af_c));
    check("almost_empty", 32'(o_ae),      32'(n <= ae_c));
    check("overflow",     32'(o_ovf),     32'(m_ovf));
    check("underflow",    32'(o_udf),     32'(m_udf));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input bit rst_lvl, input bit wr, input bit rd, input bit clr,
                       input logic [31:0] d);
    bit was_full, was_empty;
    reset = rst_lvl; wr_en = wr; rd_en = rd; clr_err = clr; din = d;
    @(posedge clk);
    #1;
    if (!rst_lvl) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (mq.size() == depth_c);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) m_dout = mq.pop_front();
      if (wr && !was_full)  mq.push_back(d & mask_c);
      m_ovf = (wr && was_full)  || (m_ovf && !clr);
      m_udf = (rd && was_empty) || (m_udf && !clr);
    end
    compare_model();
  endtask

  task automatic select(input bit s);
    sel = s;
    depth_c = s ? 7 : 10;
    af_c    = s ? 5 : 8;
    ae_c    = s ? 1 : 2;
    mask_c  = s ? 32'hFFFF_FFFF : 32'hFF;
  endtask

  task automatic random_run(input int cycles);
    int  bias;
    bit  wr, rd, clr, rl;
    for (int n = 0; n < cycles; n++) begin
      bias = ((n / 40) % 2 == 1) ? 75 : 25;
      wr   = int'($urandom_range(99)) < bias;
      rd   = int'($urandom_range(99)) < (100 - bias);
      clr  = ($urandom_range(15) == 0);
      rl   = ($urandom_range(199) != 0);
      cycle(rl, wr, rd, clr, $urandom);
    end
  endtask

  typedef struct {
    bit          rst, wr, rd, clr;
    logic [31:0] din;
    logic [31:0] dout;
    int          cnt;
    bit          full, empty, ovf, udf;
  } vec_t;

  function automatic vec_t mk(bit rst, bit wr, bit rd, bit clr, logic [31:0] d,
                              logic [31:0] dout, int cnt, bit full, bit empty,
                              bit ovf, bit udf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = d;
    v.dout = dout; v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    //            rst wr rd clr din    dout  cnt full empty ovf udf
    vecs[0]  = mk(0,  0, 0, 0, 32'h00, 32'h00, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1,  0, 1, 0, 32'h00, 32'h00, 0, 0, 1, 0, 1);
    vecs[2]  = mk(1,  0, 0, 1, 32'h00, 32'h00, 0, 0, 1, 0, 0);
    vecs[3]  = mk(1,  1, 1, 0, 32'h11, 32'h00, 1, 0, 0, 0, 1);
    vecs[4]  = mk(1,  0, 1, 1, 32'h00, 32'h11, 0, 0, 1, 0, 0);
    vecs[5]  = mk(1,  1, 0, 0, 32'h22, 32'h11, 1, 0, 0, 0, 0);
    vecs[6]  = mk(1,  1, 0, 0, 32'h33, 32'h11, 2, 0, 0, 0, 0);
    vecs[7]  = mk(1,  1, 1, 0, 32'h44, 32'h22, 2, 0, 0, 0, 0);
    vecs[8]  = mk(1,  0, 1, 0, 32'h00, 32'h33, 1, 0, 0, 0, 0);
    vecs[9]  = mk(1,  0, 1, 0, 32'h00, 32'h44, 0, 0, 1, 0, 0);
    vecs[10] = mk(1,  0, 1, 1, 32'h00, 32'h44, 0, 0, 1, 0, 1);
    vecs[11] = mk(0,  0, 0, 0, 32'h00, 32'h00, 0, 0, 1, 0, 0);

    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    select(1'b0);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      check($sformatf("tbl%0d_dout", i),  o_dout,           vecs[i].dout);
      check($sformatf("tbl%0d_count", i), o_count,          32'(vecs[i].cnt));
      check($sformatf("tbl%0d_full", i),  32'(o_full),      32'(vecs[i].full));
      check($sformatf("tbl%0d_empty", i), 32'(o_empty),     32'(vecs[i].empty));
      check($sformatf("tbl%0d_ovf", i),   32'(o_ovf),       32'(vecs[i].ovf));
      check($sformatf("tbl%0d_udf", i),   32'(o_udf),       32'(vecs[i].udf));
    end

    // Fill 0x01..0x0A, then one push too many.
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 1, 0, 0, 32'(i));
      if (i == 2) check("fill_ae_at2", 32'(o_ae), 32'd1);
      if (i == 3) check("fill_ae_at3", 32'(o_ae), 32'd0);
      if (i == 7) check("fill_af_at7", 32'(o_af), 32'd0);
      if (i == 8) check("fill_af_at8", 32'(o_af), 32'd1);
    end
    check("fill_full",  32'(o_full), 32'd1);
    check("fill_count", o_count,     32'd10);
    cycle(1, 1, 0, 0, 32'hEE);
    check("overflow_set",   32'(o_ovf), 32'd1);
    check("overflow_count", o_count,    32'd10);

    // Drain in order, then one pop too many.
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, 1, 0, '0);
      check($sformatf("drain_dout%0d", i), o_dout, 32'(i));
    end
    check("drain_empty", 32'(o_empty), 32'd1);
    cycle(1, 0, 1, 0, '0);
    check("underflow_set",  32'(o_udf), 32'd1);
    check("underflow_dout", o_dout,     32'h0A);

    // Steady state at count=5 with simultaneous push/pop across the wrap.
    cycle(1, 0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 32'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 1, 0, 32'(8'h45 + i));
      check("steady_count", o_count, 32'd5);
    end
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, '0);
    check("steady_last", o_dout, 32'h58);

    // Full with push and pop: pop wins, push rejected.
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 32'(8'h80 + i));
    cycle(1, 1, 1, 0, 32'h99);
    check("full_both_count", o_count,    32'd9);
    check("full_both_ovf",   32'(o_ovf), 32'd1);
    check("full_both_dout",  o_dout,     32'h80);

    // Empty with push and pop: push wins, pop rejected, Data_Out holds.
    cycle(1, 0, 0, 1, '0);
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, 0, '0);
    cycle(1, 1, 1, 0, 32'h77);
    check("empty_both_count", o_count,    32'd1);
    check("empty_both_udf",   32'(o_udf), 32'd1);
    check("empty_both_dout",  o_dout,     32'h89);

    // Reset at count=6, then a push in the release cycle.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 32'(8'hC0 + i));
    check("pre_reset_count", o_count, 32'd6);
    cycle(0, 0, 0, 0, '0);
    check("rst_count", o_count,      32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_dout",  o_dout,       32'd0);
    check("rst_udf",   32'(o_udf),   32'd0);
    cycle(1, 1, 0, 0, 32'h5A);
    check("release_push_count", o_count, 32'd1);
    cycle(1, 0, 1, 0, '0);
    check("release_push_dout", o_dout, 32'h5A);

    random_run(500);

    // 32-bit x 7 instance.
    select(1'b1);
    cycle(0, 0, 0, 0, '0);
    for (int i = 1; i <= 7; i++) begin
      cycle(1, 1, 0, 0, 32'hDEADBEEF ^ (32'(i) * 32'h01010101));
      if (i == 1) check("w32_ae_at1", 32'(o_ae), 32'd1);
      if (i == 2) check("w32_ae_at2", 32'(o_ae), 32'd0);
      if (i == 4) check("w32_af_at4", 32'(o_af), 32'd0);
      if (i == 5) check("w32_af_at5", 32'(o_af), 32'd1);
    end
    check("w32_full", 32'(o_full), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      cycle(1, 0, 1, 0, '0);
      check($sformatf("w32_drain%0d", i), o_dout, 32'hDEADBEEF ^ (32'(i) * 32'h01010101));
    end
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 32'hCAFE0000 + 32'(i));
    for (int i = 0; i < 12; i++) cycle(1, 1, 1, 0, 32'hCAFE0003 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, '0);
    check("w32_wrap_last", o_dout, 32'hCAFE000E);

    random_run(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock synchronous FIFO, the next-generation replacement for the fixed 8-bit × 10-entry buffer. It sits between a producer and a consumer in the same clock domain. It adds configurable width and depth, correct simultaneous push/pop accounting, an occupancy output, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 10, number of entries (≥2; need not be a power of two)
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low (0 = reset), sampled on posedge clk
- Data_In  input  WIDTH  write data, captured on accepted push
- wr_en  input  1  push request
- rd_en  input  1  pop request
- Data_Out  output  WIDTH  registered read data
- Full  output  1  count == DEPTH
- Empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: push attempted while Full
- underflow  output  1  sticky: pop attempted while Empty
- clr_err  input  1  clears overflow/underflow

## Operation
- push_ok = wr_en & !Full; pop_ok = rd_en & !Empty. Both use registered flags from the current cycle.
- push_ok: mem[wr_ptr] ← Data_In; wr_ptr advances.
- pop_ok: Data_Out ← mem[rd_ptr]; rd_ptr advances. Data_Out holds its value otherwise.
- count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers are $clog2(DEPTH) bits. Wrap explicitly from DEPTH-1 to 0; never rely on natural binary rollover.
- Full with wr_en & rd_en: pop accepted, push rejected, overflow set; count becomes DEPTH-1.
- Empty with wr_en & rd_en: push accepted, pop rejected, underflow set; Data_Out unchanged; count becomes 1.
- overflow/underflow set on the rejected request and hold until clr_err=1 or reset. If set and clear coincide, set wins.
- Flags are combinational decodes of the registered count only.
- Memory contents are not reset. Reading stale entries is impossible by construction.

## Timing
- While reset=0 at posedge: wr_ptr=rd_ptr=count=0, Data_Out=0, overflow=underflow=0; hence Empty=1, Full=0, almost_empty=1, almost_full=(AF_LEVEL==0 → never, legal range excludes).
- Reset mid-operation discards all stored data in one cycle. The first push after reset release is accepted in that same cycle.
- Read latency: Data_Out valid the cycle after the pop_ok edge.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 and appears on Data_Out after edge N+1. No fall-through.
- Flag and count updates are visible one cycle after the accepted request edge.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.

## Structure
- Package fifo_pkg holds: function clog2-based width helpers (ptr_w(DEPTH), cnt_w(DEPTH)) and a typedef'd status struct {full, empty, almost_full, almost_empty, overflow, underflow} for reuse by wrappers.
- One sub-module: fifo_ram. It is a WIDTH×DEPTH storage array with one synchronous write port, a synchronous read port, and registered output with read enable. param_sync_fifo owns pointers, count, flags and error logic.
- Parameter sanity checks (DEPTH≥2, threshold ranges) go in elaboration-time assertions.
- Concurrent assertions:
  - !(Full && Empty)
  - Full & !rd_en & reset |=> Full
  - Empty & !wr_en & reset |=> Empty
  - count ≤ DEPTH

## Test plan
- Reset then fill (defaults): 10 pushes of 0x01..0x0A → Full=1 after 10th, count=10, almost_full from count=8; 11th push sets overflow, count stays 10.
- Drain: 10 pops → Data_Out sequence 0x01..0x0A one cycle after each pop, Empty=1 at end; extra pop sets underflow, Data_Out stays 0x0A.
- Simultaneous push/pop at count=5 for 20 cycles with incrementing data → count stays 5, output order preserved across pointer wrap 9→0.
- Full + wr_en + rd_en → pop accepted, push rejected, overflow=1, count=9. Empty + both → push accepted, underflow=1, count=1.
- Reset asserted (0) with count=6 → next cycle count=0, Empty=1, Data_Out=0, errors cleared; push in the release cycle accepted.
- WIDTH=32, DEPTH=7, AF_LEVEL=5, AE_LEVEL=1 → fill/drain with 0xDEADBEEF-style patterns, flags switch at counts 5 and 1, wrap at 6→0.
